seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised, programmable serial sequence detector with Moore-style registered output. It is the generalised successor of the fixed-pattern Moore detector. It adds:
- run-time loadable pattern of parametric length
- overlap / non-overlap match mode
- input qualifier
- optional saturating match counter

It sits on a 1-bit serial data stream and flags each completed occurrence of the programmed pattern.

## Interface
- PATTERN_LEN, 4: pattern length in bits, 2..32
- RESET_PATTERN, 4'b1011: pattern loaded by reset; MSB is the first bit expected
- CNT_W, 8: match counter width, 1..32
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- sequence_in  in  1  serial data bit
- valid_in  in  1  sequence_in is consumed only on edges where valid_in=1
- pattern_in  in  PATTERN_LEN  new pattern, MSB first
- load  in  1  capture pattern_in, restart detection
- overlap_en  in  1  1: overlapping matches; 0: non-overlapping
- count_clr  in  1  clear match counter (SEQ_DET_COUNT_EN only)
- detector_out  out  1  registered match pulse; reset 0
- match_count  out  CNT_W  saturating number of matches; reset 0
- count_sat  out  1  match_count is at all-ones; reset 0

## Operation
- Internal state:
  - pattern_q (PATTERN_LEN): reset value RESET_PATTERN
  - hist_q (PATTERN_LEN): shift register; reset 0
  - fill_q (0..PATTERN_LEN): number of valid bits in history; reset 0
- Accept edge (valid_in=1, load=0):
  - hist_q <= {hist_q[PATTERN_LEN-2:0], sequence_in}
  - fill_q increments, saturating at PATTERN_LEN
- Match condition: on an accept edge, the post-shift history equals pattern_q and post-increment fill equals PATTERN_LEN. detector_out <= 1 on that edge; otherwise detector_out <= 0. This makes the output Moore-style, because it depends only on registered state.
- After a match:
  - overlap_en=1: history kept, so the next match may reuse the pattern's suffix bits.
  - overlap_en=0: fill_q <= 0, so the next match needs PATTERN_LEN fresh bits. The history contents are irrelevant until the fill is complete.
- overlap_en is sampled on every accept edge. Changing it mid-stream affects only subsequent matches.
- load=1 (has priority over valid_in):
  - pattern_q <= pattern_in; fill_q <= 0; hist_q <= 0; detector_out <= 0
  - the bit presented on that edge is discarded
  - match_count is not affected
- valid_in=0: state held, detector_out <= 0.
- Counter (SEQ_DET_COUNT_EN):
  - increments on every edge that sets detector_out, saturating at 2^CNT_W-1
  - count_sat = (match_count == all-ones), registered alongside the count
  - count_clr=1 forces the counter to 0, even when a match occurs on the same edge (clear wins)
- reset at any time: all state returns to reset values on that edge, regardless of load, valid_in or count_clr.

## Timing
- Latency: detector_out goes high in the cycle immediately after the edge that accepts the final pattern bit. It stays high exactly one cycle per match.
- Back-to-back matches on consecutive accept edges are possible only with overlap_en=1 and a self-overlapping pattern, for example all-ones. detector_out then stays high continuously.
- match_count updates on the same edge as detector_out.
- First possible match after reset or load: the PATTERN_LEN-th accept edge.
- No combinational path from any input to any output.

## Configuration
- SEQ_DET_COUNT_EN defined: the match counter, count_clr and count_sat are implemented as above.
- SEQ_DET_COUNT_EN undefined:
  - no counter registers are built
  - match_count is tied to 0 and count_sat is tied to 0
  - count_clr is ignored
  - detection behaviour is identical in both builds.

## Structure
- Shared package seq_det_pkg holds:
  - the PATTERN_LEN and CNT_W limits as constants
  - a fill-counter width function, clog2(PATTERN_LEN+1)
- One sub-module: seq_det_counter, the saturating counter with clear. It is instantiated only under SEQ_DET_COUNT_EN.
- The remaining logic (history, fill and match register) is in the top module.

## Test plan
- Reset with default pattern 1011, overlap_en=1, stream 1,0,1,1,0,1,1 -> detector_out high in the cycle after bit 4 and after bit 7; match_count=2.
- Same stream with overlap_en=0 -> single pulse after bit 4; match_count=1.
- PATTERN_LEN=4, load 1111, overlap_en=1, six consecutive 1s -> detector_out high for 3 consecutive cycles; match_count=3.
- valid_in toggled low between each bit of 1,0,1,1 -> one pulse one cycle after the 4th accepted bit; detector_out low during the idle cycles.
- load asserted with valid_in=1 mid-pattern (after 1,0,1) -> no match on the next 1; a match requires 4 new bits against the newly loaded pattern.
- CNT_W=2, five matches, then count_clr together with a sixth match -> count saturates at 3 with count_sat=1, then reads 0 and count_sat=0. A reset issued mid-pattern clears detector_out, fill, count and pattern.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared limits and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int unsigned MinPatternLen = 2;
  localparam int unsigned MaxPatternLen = 32;
  localparam int unsigned MinCntW       = 1;
  localparam int unsigned MaxCntW       = 32;

  // Fill counter must represent 0..len inclusive.
  function automatic int unsigned fill_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter with synchronous clear; sat_o is registered with the count.
module seq_det_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o,
  output logic             sat_o
);

  logic [Width-1:0] count_q, count_d;
  logic             sat_q;

  // Clear beats a same-edge increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !sat_q) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= &count_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial sequence detector with registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned               PATTERN_LEN   = 4,
  parameter logic [PATTERN_LEN-1:0]    RESET_PATTERN = 4'b1011,
  parameter int unsigned               CNT_W         = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sequence_in,
  input  logic                   valid_in,
  input  logic [PATTERN_LEN-1:0] pattern_in,
  input  logic                   load,
  input  logic                   overlap_en,
  input  logic                   count_clr,
  output logic                   detector_out,
  output logic [CNT_W-1:0]       match_count,
  output logic                   count_sat
);

  localparam int unsigned     FillW    = fill_width(PATTERN_LEN);
  localparam logic [FillW-1:0] FillFull = FillW'(PATTERN_LEN);

  if (PATTERN_LEN < MinPatternLen || PATTERN_LEN > MaxPatternLen) begin : gen_bad_len
    $error("seq_detector_param: PATTERN_LEN out of range");
  end
  if (CNT_W < MinCntW || CNT_W > MaxCntW) begin : gen_bad_cnt_w
    $error("seq_detector_param: CNT_W out of range");
  end

  logic [PATTERN_LEN-1:0] pattern_q;
  logic [PATTERN_LEN-1:0] hist_q, hist_d;
  logic [FillW-1:0]       fill_q, fill_inc;
  logic                   match;

  assign hist_d   = {hist_q[PATTERN_LEN-2:0], sequence_in};
  assign fill_inc = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
  assign match    = (hist_d == pattern_q) && (fill_inc == FillFull);

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_q    <= RESET_PATTERN;
      hist_q       <= '0;
      fill_q       <= '0;
      detector_out <= 1'b0;
    end else if (load) begin
      pattern_q    <= pattern_in;
      hist_q       <= '0;
      fill_q       <= '0;
      detector_out <= 1'b0;
    end else if (valid_in) begin
      hist_q       <= hist_d;
      // Non-overlap mode demands a full fresh window after each hit.
      fill_q       <= (match && !overlap_en) ? '0 : fill_inc;
      detector_out <= match;
    end else begin
      detector_out <= 1'b0;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic match_evt;
  assign match_evt = valid_in && !load && match;

  seq_det_counter #(
    .Width (CNT_W)
  ) u_counter (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (count_clr),
    .inc_i   (match_evt),
    .count_o (match_count),
    .sat_o   (count_sat)
  );
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count      = '0;
  assign count_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PATTERN_LEN=4, CNT_W=2).
module tb_seq_detector_param;

  localparam int unsigned PLen = 4;
  localparam int unsigned CntW = 2;
`ifdef SEQ_DET_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            sequence_in;
  logic            valid_in;
  logic [PLen-1:0] pattern_in;
  logic            load;
  logic            overlap_en;
  logic            count_clr;
  logic            detector_out;
  logic [CntW-1:0] match_count;
  logic            count_sat;

  int n_assert = 0;
  int n_fail   = 0;

  seq_detector_param #(
    .PATTERN_LEN   (PLen),
    .RESET_PATTERN (4'b1011),
    .CNT_W         (CntW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .valid_in     (valid_in),
    .pattern_in   (pattern_in),
    .load         (load),
    .overlap_en   (overlap_en),
    .count_clr    (count_clr),
    .detector_out (detector_out),
    .match_count  (match_count),
    .count_sat    (count_sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CntEn ? 32'(n) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_sat(input bit s);
    return CntEn ? {31'd0, s} : 32'd0;
  endfunction

  task automatic tick(input logic rst, input logic v, input logic b, input logic ld,
                      input logic clr);
    reset       = rst;
    valid_in    = v;
    sequence_in = b;
    load        = ld;
    count_clr   = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic b, input logic exp_det, input string tag);
    tick(1'b0, 1'b1, b, 1'b0, 1'b0);
    check(tag, {31'd0, detector_out}, {31'd0, exp_det});
  endtask

  task automatic idle(input string tag);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check(tag, {31'd0, detector_out}, 32'd0);
  endtask

  task automatic check_cnt(input string tag, input int n, input bit s);
    check({tag, "_cnt"}, {{(32-CntW){1'b0}}, match_count}, exp_cnt(n));
    check({tag, "_sat"}, {31'd0, count_sat}, exp_sat(s));
  endtask

  initial begin
    pattern_in = '0;
    overlap_en = 1'b1;

    // Reset state
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_det", {31'd0, detector_out}, 32'd0);
    check_cnt("rst", 0, 1'b0);

    // Default 1011, overlapping
    overlap_en = 1'b1;
    send(1, 0, "ov_b1"); send(0, 0, "ov_b2"); send(1, 0, "ov_b3"); send(1, 1, "ov_b4");
    send(0, 0, "ov_b5"); send(1, 0, "ov_b6"); send(1, 1, "ov_b7");
    check_cnt("ov", 2, 1'b0);

    // Same stream, non-overlapping
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    overlap_en = 1'b0;
    send(1, 0, "no_b1"); send(0, 0, "no_b2"); send(1, 0, "no_b3"); send(1, 1, "no_b4");
    send(0, 0, "no_b5"); send(1, 0, "no_b6"); send(1, 0, "no_b7");
    check_cnt("no", 1, 1'b0);

    // Load 1111, six ones, overlapping: three back-to-back pulses; count saturates at 3
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    overlap_en = 1'b1;
    pattern_in = 4'b1111;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("ones_ld_det", {31'd0, detector_out}, 32'd0);
    send(1, 0, "ones_1"); send(1, 0, "ones_2"); send(1, 0, "ones_3");
    send(1, 1, "ones_4"); send(1, 1, "ones_5"); send(1, 1, "ones_6");
    check_cnt("ones", 3, 1'b1);

    // valid_in gaps between the bits of 1011
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1, 0, "gap_b1"); idle("gap_i1");
    send(0, 0, "gap_b2"); idle("gap_i2");
    send(1, 0, "gap_b3"); idle("gap_i3");
    send(1, 1, "gap_b4"); idle("gap_i4");
    check_cnt("gap", 1, 1'b0);

    // Load mid-pattern with valid_in=1; loaded bit discarded, new pattern 0110
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1, 0, "ld_b1"); send(0, 0, "ld_b2"); send(1, 0, "ld_b3");
    pattern_in = 4'b0110;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("ld_edge_det", {31'd0, detector_out}, 32'd0);
    send(0, 0, "ld_n1"); send(1, 0, "ld_n2"); send(1, 0, "ld_n3"); send(0, 1, "ld_n4");
    check_cnt("ld", 1, 1'b0);

    // CNT_W=2: five matches saturate, then clear with a sixth match
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pattern_in = 4'b1111;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1, 0, "sat_1"); send(1, 0, "sat_2"); send(1, 0, "sat_3");
    send(1, 1, "sat_m1"); send(1, 1, "sat_m2");
    check_cnt("sat_two", 2, 1'b0);
    send(1, 1, "sat_m3"); send(1, 1, "sat_m4"); send(1, 1, "sat_m5");
    check_cnt("sat_five", 3, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_det", {31'd0, detector_out}, 32'd1);
    check_cnt("clr", 0, 1'b0);

    // Reset mid-pattern wins over load/valid/count_clr and restores 1011
    send(1, 1, "mr_pre");
    pattern_in = 4'b0000;
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("mr_det", {31'd0, detector_out}, 32'd0);
    check_cnt("mr", 0, 1'b0);
    send(1, 0, "mr_b1"); send(0, 0, "mr_b2"); send(1, 0, "mr_b3"); send(1, 1, "mr_b4");
    check_cnt("mr_post", 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
